ysyx_24100006_axil_master: RTL and testbench
============================================

YSYX_24100006_AXIL_MASTER -- requirements
Module: ysyx_24100006_axil_master

Interface
REQ-001 Parameter: RDATA_ON_ERR, 32'h0000_0000, value driven on resp_rdata when a read completes with rresp != 2'b00.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 Ports (name  direction  width  meaning):
  clk  in  1  clock
  reset  in  1  synchronous active-high reset
  req_valid  in  1  CPU-side request present
  req_ready  out  1  block can accept a request
  req_wen  in  1  1 = write, 0 = read
  req_addr  in  32  byte address
  req_wdata  in  32  write data
  req_wmask  in  8  byte-enable mask
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  read data
  resp_err  out  1  completion carried a non-OKAY response
  resp_code  out  2  raw rresp/bresp of the completed transaction
  axi_araddr, axi_arvalid  out  32, 1  read-address channel
  axi_arready  in  1  read-address accepted
  axi_rvalid, axi_rdata, axi_rresp  in  1, 32, 2  read-data channel
  axi_rready  out  1  read-data accept
  axi_awaddr, axi_awvalid  out  32, 1  write-address channel
  axi_awready  in  1  write-address accepted
  axi_wdata, axi_bytes, axi_wvalid  out  32, 8, 1  write-data channel
  axi_wready  in  1  write-data accepted
  axi_bvalid, axi_bresp  in  1, 2  write-response channel
  axi_bready  out  1  write-response accept

Function
REQ-004 States: IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
REQ-005 req_ready = 1 only in IDLE; the request is captured into internal registers on req_valid & req_ready.
REQ-006 Read: IDLE -> RADDR; axi_arvalid = 1 from the cycle after capture, held until the axi_arvalid & axi_arready edge, then 0 -> RDATA.
REQ-007 RDATA: axi_rready = 1; on axi_rvalid & axi_rready capture rdata/rresp -> DONE.
REQ-008 Write: IDLE -> WRITE; axi_awvalid and axi_wvalid = 1 from the cycle after capture.
REQ-009 WRITE: each valid drops independently on its own handshake edge and is never reasserted; both handshakes in the same cycle are legal; -> WRESP when both are complete.
REQ-010 WRESP: axi_bready = 1; on axi_bvalid & axi_bready capture bresp -> DONE.
REQ-011 DONE: resp_valid = 1 for exactly one cycle, with no back-pressure; -> IDLE; a new request can be accepted the next cycle.
REQ-012 Minimum latency, with a slave ready in zero cycles: accept at cycle 0, resp_valid at cycle 3.
REQ-013 resp_err = (code != 2'b00); resp_rdata = RDATA_ON_ERR on a read error; resp_rdata holds its last value after a write.
REQ-014 Address, data and mask SHALL stay stable while the corresponding valid is high.
REQ-015 Inputs on the R/B channels outside RDATA/WRESP SHALL be ignored, with no state change.
REQ-016 No timeout: the block waits indefinitely for the slave.

Reset
REQ-017 On reset: state = IDLE; all axi_*valid, axi_rready, axi_bready and resp_valid = 0; resp_rdata = 0; resp_err = 0; resp_code = 0; axi address/data/mask = 0.
REQ-018 Reset mid-transaction SHALL drop every valid/ready on that same clock edge, with no completion pulse.

Structure
REQ-019 Package ysyx_24100006_axil_pkg SHALL hold the state enumeration and the response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11, shared with the slave blocks.
REQ-020 Single flat module; no sub-module.

Verification
REQ-021 Read with the UART slave attached, addr 32'ha000_03f8 -> arvalid held until arready, then resp_valid with resp_code = 2'b01, resp_err = 1, resp_rdata = 32'h0.
REQ-022 Write 32'h0000_0041, mask 8'h01, to the UART -> "A" printed once, resp_code = 2'b00, resp_err = 0, one resp_valid pulse.
REQ-023 Memory slave with awready 3 cycles before wready -> awvalid drops first, wvalid held until its own handshake, bready only after both.
REQ-024 Zero-wait slave, back-to-back reads while req_valid is held high -> a completion every 4 cycles, req_ready low while busy.
REQ-025 Reset asserted during RDATA with rvalid low -> next cycle all valids 0, state IDLE, no resp_valid; a following read completes normally.

Source files
------------

// File: rtl/ysyx_24100006_axil_pkg.sv
// Shared AXI-Lite definitions: master state encoding, response codes, bus widths.
// Response constants are common to the master and the slave blocks.
package ysyx_24100006_axil_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 8;
   localparam int unsigned RESP_W = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WRITE = 3'd3,
      WRESP = 3'd4,
      DONE  = 3'd5
   } axil_state_t;

   localparam logic [RESP_W-1:0] OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] EXOKAY = 2'b01;
   localparam logic [RESP_W-1:0] SLVERR = 2'b10;
   localparam logic [RESP_W-1:0] DECERR = 2'b11;

   // Anything other than OKAY is reported to the CPU as an error.
   function automatic logic resp_is_err(input logic [RESP_W-1:0] code);
      return code != OKAY;
   endfunction

endpackage

// File: rtl/ysyx_24100006_axil_master.sv
// AXI-Lite master: turns one CPU request at a time into an AXI-Lite read or
// write and returns a single-cycle completion pulse with data and response.
module ysyx_24100006_axil_master
   import ysyx_24100006_axil_pkg::*;
#(
   parameter logic [DATA_W-1:0] RDATA_ON_ERR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wmask,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [RESP_W-1:0] resp_code,
   output logic [ADDR_W-1:0] axi_araddr,
   output logic              axi_arvalid,
   input  logic              axi_arready,
   input  logic              axi_rvalid,
   input  logic [DATA_W-1:0] axi_rdata,
   input  logic [RESP_W-1:0] axi_rresp,
   output logic              axi_rready,
   output logic [ADDR_W-1:0] axi_awaddr,
   output logic              axi_awvalid,
   input  logic              axi_awready,
   output logic [DATA_W-1:0] axi_wdata,
   output logic [STRB_W-1:0] axi_bytes,
   output logic              axi_wvalid,
   input  logic              axi_wready,
   input  logic              axi_bvalid,
   input  logic [RESP_W-1:0] axi_bresp,
   output logic              axi_bready
);

   axil_state_t r_state;

   logic w_accept;
   logic w_ar_hs;
   logic w_r_hs;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_b_hs;
   logic w_aw_done;
   logic w_w_done;

   assign w_accept  = req_valid & req_ready;
   assign w_ar_hs   = axi_arvalid & axi_arready;
   assign w_r_hs    = axi_rvalid & axi_rready;
   assign w_aw_hs   = axi_awvalid & axi_awready;
   assign w_w_hs    = axi_wvalid & axi_wready;
   assign w_b_hs    = axi_bvalid & axi_bready;
   // A write channel is finished once its valid has dropped or is handshaking now.
   assign w_aw_done = ~axi_awvalid | axi_awready;
   assign w_w_done  = ~axi_wvalid | axi_wready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
         resp_code   <= OKAY;
         axi_araddr  <= '0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
         axi_awaddr  <= '0;
         axi_awvalid <= 1'b0;
         axi_wdata   <= '0;
         axi_bytes   <= '0;
         axi_wvalid  <= 1'b0;
         axi_bready  <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  req_ready <= 1'b0;
                  if (req_wen) begin
                     axi_awaddr  <= req_addr;
                     axi_wdata   <= req_wdata;
                     axi_bytes   <= req_wmask;
                     axi_awvalid <= 1'b1;
                     axi_wvalid  <= 1'b1;
                     r_state     <= WRITE;
                  end else begin
                     axi_araddr  <= req_addr;
                     axi_arvalid <= 1'b1;
                     r_state     <= RADDR;
                  end
               end
            end
            RADDR: begin
               if (w_ar_hs) begin
                  axi_arvalid <= 1'b0;
                  axi_rready  <= 1'b1;
                  r_state     <= RDATA;
               end
            end
            RDATA: begin
               if (w_r_hs) begin
                  axi_rready <= 1'b0;
                  resp_code  <= axi_rresp;
                  resp_err   <= resp_is_err(axi_rresp);
                  resp_rdata <= resp_is_err(axi_rresp) ? RDATA_ON_ERR : axi_rdata;
                  resp_valid <= 1'b1;
                  r_state    <= DONE;
               end
            end
            WRITE: begin
               // Each valid drops on its own handshake and is never raised again.
               if (w_aw_hs) axi_awvalid <= 1'b0;
               if (w_w_hs)  axi_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  axi_bready <= 1'b1;
                  r_state    <= WRESP;
               end
            end
            WRESP: begin
               if (w_b_hs) begin
                  axi_bready <= 1'b0;
                  resp_code  <= axi_bresp;
                  resp_err   <= resp_is_err(axi_bresp);
                  resp_valid <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               req_ready <= 1'b1;
               r_state   <= IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               r_state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24100006_axil_master.sv
// Directed bench for the AXI-Lite master with a latency-configurable slave
// model and a response scoreboard.
module tb_ysyx_24100006_axil_master;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  code;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [1:0]  resp_code;
   logic [31:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready;
   logic        axi_rvalid;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rready;
   logic [31:0] axi_awaddr;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_wdata;
   logic [7:0]  axi_bytes;
   logic        axi_wvalid;
   logic        axi_wready;
   logic        axi_bvalid;
   logic [1:0]  axi_bresp;
   logic        axi_bready;

   // Slave configuration, written by the stimulus process.
   int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
   logic [31:0] rdata_val = '0;
   logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;
   logic        spur_r = 1'b0, spur_b = 1'b0;

   // Slave state.
   int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   logic        r_pend, aw_got, w_got, b_pend;
   int          uart_wr_cnt;
   logic [31:0] last_wdata, last_awaddr;
   logic [7:0]  last_strb;
   logic        r_vld, b_vld;

   localparam logic [31:0] UART_ADDR = 32'ha000_03f8;

   int   compared = 0;
   int   mismatched = 0;
   exp_t sb[$];
   logic [31:0] model_rdata = '0;
   int   lat;

   ysyx_24100006_axil_master #(.RDATA_ON_ERR(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .resp_code(resp_code),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_bytes(axi_bytes), .axi_wvalid(axi_wvalid),
      .axi_wready(axi_wready),
      .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready)
   );

   always #5 clk = ~clk;

   assign axi_arready = axi_arvalid && (ar_cnt >= ar_lat);
   assign axi_awready = axi_awvalid && (aw_cnt >= aw_lat);
   assign axi_wready  = axi_wvalid && (w_cnt >= w_lat);
   assign r_vld       = r_pend && (r_cnt >= r_lat);
   assign b_vld       = b_pend && (b_cnt >= b_lat);
   assign axi_rvalid  = r_vld | spur_r;
   assign axi_bvalid  = b_vld | spur_b;
   assign axi_rdata   = rdata_val;
   assign axi_rresp   = rresp_val;
   assign axi_bresp   = bresp_val;

   // Slave model: ready after a programmable number of waiting cycles.
   always @(posedge clk) begin
      if (reset) begin
         ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
         r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      end else begin
         ar_cnt <= (axi_arvalid && !axi_arready) ? ar_cnt + 1 : 0;
         aw_cnt <= (axi_awvalid && !axi_awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (axi_wvalid && !axi_wready) ? w_cnt + 1 : 0;
         if (axi_arvalid && axi_arready) begin
            r_pend <= 1'b1; r_cnt <= 0;
         end else if (r_vld && axi_rready) begin
            r_pend <= 1'b0;
         end else if (r_pend) begin
            r_cnt <= r_cnt + 1;
         end
         if (b_vld && axi_bready) b_pend <= 1'b0;
         else if (b_pend) b_cnt <= b_cnt + 1;
         if ((aw_got || (axi_awvalid && axi_awready)) && (w_got || (axi_wvalid && axi_wready))) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
         end else begin
            aw_got <= aw_got || (axi_awvalid && axi_awready);
            w_got  <= w_got || (axi_wvalid && axi_wready);
         end
         if (axi_wvalid && axi_wready) begin
            last_wdata  <= axi_wdata;
            last_strb   <= axi_bytes;
            last_awaddr <= axi_awaddr;
            if (axi_awaddr == UART_ADDR) uart_wr_cnt <= uart_wr_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push the expected completion for a request about to be issued.
   task automatic push_exp(input logic wen);
      exp_t e;
      if (wen) begin
         e.rdata = model_rdata;
         e.code  = bresp_val;
      end else begin
         e.rdata = (rresp_val != 2'b00) ? 32'h0 : rdata_val;
         e.code  = rresp_val;
         model_rdata = e.rdata;
      end
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
         chk({tag, "_code"}, 64'(resp_code), 64'(e.code));
         chk({tag, "_err"}, 64'(resp_err), 64'(e.code != 2'b00));
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accept edge.
   task automatic send(input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] wmask);
      int n = 0;
      req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
      req_valid = 1'b1;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      chk("send_accept", 64'(req_ready), 64'(1));
      push_exp(wen);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag, output int latency);
      int n = 0;
      while (!resp_valid && n < 200) begin @(negedge clk); n++; end
      chk({tag, "_resp_seen"}, 64'(resp_valid), 64'(1));
      if (resp_valid) pop_cmp(tag);
      latency = n;
      @(negedge clk);
      chk({tag, "_pulse_one"}, 64'(resp_valid), 64'(0));
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_valids", 64'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, resp_valid}), 64'(0));
      chk("rst_resp", 64'({resp_rdata, resp_err, resp_code}), 64'(0));
      chk("rst_addr", 64'({axi_araddr, axi_awaddr}), 64'(0));
      chk("rst_data", 64'({axi_wdata, axi_bytes}), 64'(0));
      uart_wr_cnt = 0;

      // Spurious R/B valids in IDLE are ignored
      spur_r = 1'b1; spur_b = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("spur_idle", 64'({resp_valid, req_ready, axi_rready, axi_bready}), 64'(4'b0100));
      end
      spur_r = 1'b0; spur_b = 1'b0;

      // Zero-wait read: minimum latency
      rdata_val = 32'h1122_3344; rresp_val = 2'b00;
      send(1'b0, 32'h8000_0010, 32'h0, 8'h00);
      chk("rd0_araddr", 64'(axi_araddr), 64'(32'h8000_0010));
      wait_resp("rd0", lat);
      chk("rd0_latency", 64'(lat), 64'(2));

      // Zero-wait write: rdata holds from the previous read
      bresp_val = 2'b00;
      send(1'b1, 32'h8000_0020, 32'hCAFE_F00D, 8'h0F);
      wait_resp("wr0", lat);
      chk("wr0_latency", 64'(lat), 64'(2));
      chk("wr0_slave_data", 64'({last_awaddr, last_wdata}), {32'h8000_0020, 32'hCAFE_F00D});
      chk("wr0_slave_strb", 64'(last_strb), 64'(8'h0F));

      // UART read: arvalid held until arready, EXOKAY reported as error
      ar_lat = 2; rdata_val = 32'h1234_5678; rresp_val = 2'b01;
      send(1'b0, UART_ADDR, 32'h0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         chk("uart_rd_arvalid_hold", 64'({axi_arvalid, axi_araddr}), {31'h0, 1'b1, UART_ADDR});
         @(negedge clk);
      end
      chk("uart_rd_ar_drop", 64'({axi_arvalid, axi_rready}), 64'(2'b01));
      wait_resp("uart_rd", lat);
      ar_lat = 0;

      // UART write 'A': exactly one data beat reaches the slave
      bresp_val = 2'b00;
      send(1'b1, UART_ADDR, 32'h0000_0041, 8'h01);
      wait_resp("uart_wr", lat);
      chk("uart_wr_count", 64'(uart_wr_cnt), 64'(1));
      chk("uart_wr_data", 64'({last_wdata, last_strb}), 64'({32'h0000_0041, 8'h01}));

      // awready three cycles ahead of wready
      aw_lat = 0; w_lat = 3; b_lat = 1; bresp_val = 2'b10;
      send(1'b1, 32'h8000_0100, 32'hA5A5_5A5A, 8'hF0);
      chk("split_both_valid", 64'({axi_awvalid, axi_wvalid, axi_bready}), 64'(3'b110));
      @(negedge clk);
      for (int k = 0; k < 20 && axi_wvalid; k++) begin
         chk("split_aw_first", 64'({axi_awvalid, axi_bready}), 64'(0));
         chk("split_w_stable", 64'({axi_wdata, axi_bytes}), 64'({32'hA5A5_5A5A, 8'hF0}));
         @(negedge clk);
      end
      chk("split_bready_after", 64'({axi_wvalid, axi_bready}), 64'(2'b01));
      wait_resp("split", lat);
      w_lat = 0; b_lat = 0;

      // Slow read returning DECERR
      r_lat = 2; rdata_val = 32'hFFFF_0000; rresp_val = 2'b11;
      send(1'b0, 32'h9000_0000, 32'h0, 8'h00);
      wait_resp("decerr", lat);
      r_lat = 0;

      // Back-to-back reads with req_valid held high
      rdata_val = 32'h0BAD_CAFE; rresp_val = 2'b00;
      begin
         int got = 0;
         int last = 0;
         req_wen = 1'b0; req_addr = 32'h8000_0200; req_valid = 1'b1;
         for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            chk("b2b_ready", 64'(req_ready), 64'(cyc % 4 == 0));
            if (req_ready && req_valid) push_exp(1'b0);
            if (resp_valid) begin
               pop_cmp("b2b");
               if (got > 0) chk("b2b_period", 64'(cyc - last), 64'(4));
               last = cyc;
               got++;
               if (got == 3) req_valid = 1'b0;
            end
            @(negedge clk);
         end
         chk("b2b_count", 64'(got), 64'(3));
      end

      // Reset while waiting in RDATA
      r_lat = 1000;
      send(1'b0, 32'h8000_0300, 32'h0, 8'h00);
      for (int k = 0; k < 10 && !axi_rready; k++) @(negedge clk);
      chk("rst_mid_in_rdata", 64'(axi_rready), 64'(1));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      model_rdata = 32'h0;
      chk("rst_mid_valids", 64'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, resp_valid}), 64'(0));
      chk("rst_mid_idle", 64'(req_ready), 64'(1));
      chk("rst_mid_rdata", 64'(resp_rdata), 64'(0));
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_no_resp", 64'(resp_valid), 64'(0));
      end
      r_lat = 0; rdata_val = 32'h7777_1234; rresp_val = 2'b00;
      send(1'b0, 32'h8000_0304, 32'h0, 8'h00);
      wait_resp("post_rst", lat);
      chk("post_rst_latency", 64'(lat), 64'(2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
